unified_mem_arbiter: RTL and testbench

//  Shares one single-ported unified memory between IF-stage fetches and MEM-stage loads/stores.

---
 rtl/unified_mem_arbiter_pkg.sv | 31 +++
 rtl/unified_mem_arbiter_if.sv | 49 ++++
 rtl/unified_mem_arbiter_arb_tag_fifo.sv | 67 ++++++
 rtl/unified_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and defaults for the unified memory arbiter.
// A tag records who owns each outstanding memory request, so that in-order
// responses can be routed back to the right pipeline stage.
package unified_mem_arbiter_pkg;

  localparam int ARB_MAX_OUTST_DEF    = 4;
  localparam int ARB_STARVE_LIMIT_DEF = 8;
  localparam logic [3:0] ARB_FETCH_BE = 4'hF;

  typedef enum logic {
    ARB_IF = 1'b0,
    ARB_DM = 1'b1
  } arb_owner_t;

  // store marks a DM write, whose acknowledge carries zero data.
  typedef struct packed {
    arb_owner_t owner;
    logic       killed;
    logic       store;
  } arb_tag_t;

  // Fresh tag for a request accepted this cycle; never born killed.
  function automatic arb_tag_t arb_new_tag(input arb_owner_t owner, input logic store);
    arb_tag_t t;
    t.owner  = owner;
    t.killed = 1'b0;
    t.store  = store;
    return t;
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the pipeline stages, the arbiter and the memory model.
//
// Handshake: a requester raises *_req and holds it (with stable fields) until
// it sees the matching *_gnt high; a transfer happens exactly in a cycle where
// req and gnt are both high. Responses (*_rvalid) carry no back-pressure and
// are consumed in the cycle they are presented, in request order.
//
// slave  : the arbiter's view (serves the pipeline, drives the memory port).
// master : the environment's view (pipeline stages plus memory model).
interface unified_mem_arbiter_if;

  logic        flush_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i;
  logic [31:0] dm_addr_i;
  logic        dm_we_i;
  logic [3:0]  dm_be_i;
  logic [31:0] dm_wdata_i;
  logic        dm_gnt_o;
  logic        dm_rvalid_o;
  logic [31:0] dm_rdata_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  flush_i, if_req_i, if_addr_i, dm_req_i, dm_addr_i, dm_we_i, dm_be_i, dm_wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
  );

  modport master (
    output flush_i, if_req_i, if_addr_i, dm_req_i, dm_addr_i, dm_we_i, dm_be_i, dm_wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
  );

endinterface

// File: rtl/unified_mem_arbiter_arb_tag_fifo.sv
// Ordered FIFO of request tags, one entry per accepted-but-unanswered request.
// kill_i marks every IF entry currently stored as killed; an entry pushed in
// the same cycle is written unkilled because the push overrides the kill.
module arb_tag_fifo
  import unified_mem_arbiter_pkg::*;
#(
  parameter  int DEPTH = ARB_MAX_OUTST_DEF,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  arb_tag_t      push_tag_i,
  input  logic          pop_i,
  input  logic          kill_if_i,
  output arb_tag_t      head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  arb_tag_t      tags_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = tags_q[rd_ptr_q];
  assign count_o = count_q;

  // Occupancy follows push/pop; both together leave it unchanged.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  // Tag storage and pointers; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) tags_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (kill_if_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (tags_q[i].owner == ARB_IF) tags_q[i].killed <= 1'b1;
        end
      end
      if (do_push) begin
        tags_q[wr_ptr_q] <= push_tag_i;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // The arbiter never offers a request while full, so a push here is a bug upstream.
  assert property (@(posedge clk) disable iff (!rst) !(push_i && full_o));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Unified memory arbiter: shares one single-ported memory between IF fetches
// and MEM-stage loads/stores. DM normally wins; IF is forced through after
// STARVE_LIMIT consecutive denied cycles. Responses return in order and are
// routed combinationally to their owner using the tag FIFO; fetches killed
// by a flush are dropped.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter  int MAX_OUTST    = ARB_MAX_OUTST_DEF,
  parameter  int STARVE_LIMIT = ARB_STARVE_LIMIT_DEF,
  localparam int SW           = $clog2(STARVE_LIMIT + 1),
  localparam int CW           = $clog2(MAX_OUTST + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  unified_mem_arbiter_if.slave  bus,
  output logic [SW-1:0]         starve_cnt_o,
  output logic [CW-1:0]         tag_cnt_o
);

  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          stale_ok_q, stale_ok_d;
  logic          starved;
  logic          if_wins, dm_wins;
  logic          mem_req;
  logic [31:0]   mem_addr, mem_wdata;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic          if_gnt, dm_gnt, accept;
  logic          fifo_full, fifo_empty, pop;
  logic          rsp_valid;
  arb_tag_t      head_tag, push_tag;
  logic          if_rvalid, dm_rvalid;
  logic [31:0]   if_rdata, dm_rdata;

  assign starved = (starve_cnt_q == SW'(STARVE_LIMIT));

  // Pick a winner: nothing while the tag FIFO is full (or in reset), else DM unless IF is starved.
  always_comb begin
    if_wins = 1'b0;
    dm_wins = 1'b0;
    if (rst && !fifo_full) begin
      if (bus.if_req_i && (starved || !bus.dm_req_i)) if_wins = 1'b1;
      else if (bus.dm_req_i)                          dm_wins = 1'b1;
    end
  end

  // The winner's fields drive the memory port; fetches are full-word reads.
  always_comb begin
    mem_req   = if_wins | dm_wins;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_wdata = '0;
    if (dm_wins) begin
      mem_addr  = bus.dm_addr_i;
      mem_we    = bus.dm_we_i;
      mem_be    = bus.dm_be_i;
      mem_wdata = bus.dm_wdata_i;
    end else if (if_wins) begin
      mem_addr  = bus.if_addr_i;
      mem_be    = ARB_FETCH_BE;
    end
  end

  assign if_gnt   = if_wins & bus.mem_gnt_i;
  assign dm_gnt   = dm_wins & bus.mem_gnt_i;
  assign accept   = mem_req & bus.mem_gnt_i;
  assign push_tag = arb_new_tag(dm_wins ? ARB_DM : ARB_IF, dm_wins & bus.dm_we_i);

  assign rsp_valid = bus.mem_rvalid_i;
  assign pop       = rst & rsp_valid & ~fifo_empty;

  arb_tag_fifo #(.DEPTH(MAX_OUTST)) u_tag_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (accept),
    .push_tag_i (push_tag),
    .pop_i      (pop),
    .kill_if_i  (bus.flush_i),
    .head_o     (head_tag),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (tag_cnt_o)
  );

  // Route the head-of-line response to its owner; killed fetches and fetches
  // answered during a flush cycle vanish.
  always_comb begin
    if_rvalid = 1'b0;
    dm_rvalid = 1'b0;
    if_rdata  = '0;
    dm_rdata  = '0;
    if (pop) begin
      if (head_tag.owner == ARB_DM) begin
        dm_rvalid = 1'b1;
        dm_rdata  = head_tag.store ? 32'h0 : bus.mem_rdata_i;
      end else if (!head_tag.killed && !bus.flush_i) begin
        if_rvalid = 1'b1;
        if_rdata  = bus.mem_rdata_i;
      end
    end
  end

  // Starve counter saturates at the limit and clears on a fetch grant or idle IF.
  always_comb begin
    starve_cnt_d = '0;
    if (bus.if_req_i && !if_gnt) starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + SW'(1);
  end

  // Stale-response window: open after reset until the first new acceptance.
  assign stale_ok_d = stale_ok_q & ~accept;

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
      stale_ok_q   <= 1'b1;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      stale_ok_q   <= stale_ok_d;
    end
  end

  assign bus.mem_req_o   = mem_req;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_be_o    = mem_be;
  assign bus.mem_wdata_o = mem_wdata;
  assign bus.if_gnt_o    = if_gnt;
  assign bus.dm_gnt_o    = dm_gnt;
  assign bus.if_rvalid_o = if_rvalid;
  assign bus.if_rdata_o  = if_rdata;
  assign bus.dm_rvalid_o = dm_rvalid;
  assign bus.dm_rdata_o  = dm_rdata;
  assign starve_cnt_o    = starve_cnt_q;

  // A response with nothing outstanding is a protocol error, except for
  // traffic that was already in flight when reset hit.
  assert property (@(posedge clk) disable iff (!rst) !(rsp_valid && fifo_empty && !stale_ok_q));

  // At most one requester is granted per cycle.
  assert property (@(posedge clk) disable iff (!rst) !(if_gnt && dm_gnt));

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: table of single-cycle arbitration vectors,
// then directed sequences for reset, contention, ordering, flush and full.
// Responses are checked by a scoreboard fed whenever the bench drives a
// memory response that should reach a requester.
module tb_unified_mem_arbiter;
  import unified_mem_arbiter_pkg::*;

  localparam int W = 33;  // {owner(1=DM), data}

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] starve_cnt;
  logic [2:0] tag_cnt;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [W-1:0] exp_q[$];

  unified_mem_arbiter_if bus();

  unified_mem_arbiter #(.MAX_OUTST(4), .STARVE_LIMIT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .starve_cnt_o (starve_cnt),
    .tag_cnt_o    (tag_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.flush_i      = 1'b0;
    bus.if_req_i     = 1'b0;
    bus.if_addr_i    = '0;
    bus.dm_req_i     = 1'b0;
    bus.dm_addr_i    = '0;
    bus.dm_we_i      = 1'b0;
    bus.dm_be_i      = '0;
    bus.dm_wdata_i   = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
  endtask

  task automatic drive_if(input logic [31:0] addr);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = addr;
  endtask

  task automatic drive_dm(input logic [31:0] addr, input logic we, input logic [3:0] be,
                          input logic [31:0] wdata);
    bus.dm_req_i   = 1'b1;
    bus.dm_addr_i  = addr;
    bus.dm_we_i    = we;
    bus.dm_be_i    = be;
    bus.dm_wdata_i = wdata;
  endtask

  task automatic respond(input logic [31:0] data);
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = data;
  endtask

  task automatic expect_rsp(input logic dm_owner, input logic [31:0] data);
    exp_q.push_back({dm_owner, data});
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin : scoreboard
    logic [W-1:0] e;
    logic [W-1:0] act;
    if (rst === 1'b1 && (bus.if_rvalid_o || bus.dm_rvalid_o)) begin
      act = {bus.dm_rvalid_o, bus.dm_rvalid_o ? bus.dm_rdata_o : bus.if_rdata_o};
      n_checks++;
      if (bus.if_rvalid_o && bus.dm_rvalid_o) begin
        n_fail++;
        $display("FAIL rsp_both: if_rvalid and dm_rvalid both high");
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got owner=%0b data=0x%08h expected no response",
                 act[W-1], act[31:0]);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL rsp_data: got owner=%0b data=0x%08h expected owner=%0b data=0x%08h",
                   act[W-1], act[31:0], e[W-1], e[31:0]);
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic [31:0] dm_addr;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        mem_gnt;
    logic        exp_if_gnt;
    logic        exp_dm_gnt;
    logic        exp_mem_req;
    logic        exp_dm_win;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vecs[8];

  initial begin : main
    logic        exp_if;
    logic [31:0] d;

    vecs[0] = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 4'h0,    32'h0,        1'b1,
                1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 4'h0};
    vecs[1] = '{1'b1, 32'h100, 1'b0, 32'h0,    1'b0, 4'h0,    32'h0,        1'b1,
                1'b1, 1'b0, 1'b1, 1'b0, 32'h100,  1'b0, 4'hF};
    vecs[2] = '{1'b1, 32'h104, 1'b0, 32'h0,    1'b0, 4'h0,    32'h0,        1'b0,
                1'b0, 1'b0, 1'b1, 1'b0, 32'h104,  1'b0, 4'hF};
    vecs[3] = '{1'b0, 32'h0,   1'b1, 32'h2000, 1'b0, 4'hF,    32'h0,        1'b1,
                1'b0, 1'b1, 1'b1, 1'b1, 32'h2000, 1'b0, 4'hF};
    vecs[4] = '{1'b1, 32'h108, 1'b1, 32'h3000, 1'b0, 4'hF,    32'h0,        1'b1,
                1'b0, 1'b1, 1'b1, 1'b1, 32'h3000, 1'b0, 4'hF};
    vecs[5] = '{1'b1, 32'h10C, 1'b1, 32'h3004, 1'b0, 4'hC,    32'h0,        1'b0,
                1'b0, 1'b0, 1'b1, 1'b1, 32'h3004, 1'b0, 4'hC};
    vecs[6] = '{1'b0, 32'h0,   1'b1, 32'h44,   1'b1, 4'b0011, 32'hDEADBEEF, 1'b1,
                1'b0, 1'b1, 1'b1, 1'b1, 32'h44,   1'b1, 4'b0011};
    vecs[7] = '{1'b1, 32'h110, 1'b1, 32'h48,   1'b1, 4'b1000, 32'h0BADF00D, 1'b1,
                1'b0, 1'b1, 1'b1, 1'b1, 32'h48,   1'b1, 4'b1000};

    clear_inputs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // reset state
    sample();
    chk1("rst_mem_req", bus.mem_req_o, 1'b0);
    chk1("rst_if_rvalid", bus.if_rvalid_o, 1'b0);
    chk1("rst_dm_rvalid", bus.dm_rvalid_o, 1'b0);
    chk32("rst_tag_cnt", 32'(tag_cnt), 32'd0);
    chk32("rst_starve", 32'(starve_cnt), 32'd0);
    tick();

    // ---- reset mid-operation ----
    drive_if(32'h10);
    bus.mem_gnt_i = 1'b1;
    sample();
    chk1("r1_if_gnt", bus.if_gnt_o, 1'b1);
    tick();
    bus.if_req_i = 1'b0;
    drive_dm(32'h20, 1'b0, 4'hF, 32'h0);
    sample();
    chk1("r1_dm_gnt", bus.dm_gnt_o, 1'b1);
    tick();
    clear_inputs();
    sample();
    chk32("r1_tag_cnt_before", 32'(tag_cnt), 32'd2);
    tick();
    rst = 1'b0;
    drive_if(32'h30);
    drive_dm(32'h34, 1'b1, 4'hF, 32'h1234);
    bus.mem_gnt_i = 1'b1;
    respond(32'h77);
    sample();
    chk1("r1_mem_req", bus.mem_req_o, 1'b0);
    chk32("r1_mem_addr", bus.mem_addr_o, 32'h0);
    chk1("r1_if_gnt_rst", bus.if_gnt_o, 1'b0);
    chk1("r1_dm_gnt_rst", bus.dm_gnt_o, 1'b0);
    chk1("r1_if_rvalid_rst", bus.if_rvalid_o, 1'b0);
    chk1("r1_dm_rvalid_rst", bus.dm_rvalid_o, 1'b0);
    chk32("r1_tag_cnt_rst", 32'(tag_cnt), 32'd0);
    tick();
    clear_inputs();
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      respond(32'h78 + 32'(s));
      sample();
      chk1("r1_stale_if_rvalid", bus.if_rvalid_o, 1'b0);
      chk1("r1_stale_dm_rvalid", bus.dm_rvalid_o, 1'b0);
      tick();
    end
    clear_inputs();

    // ---- table-driven arbitration vectors ----
    for (int i = 0; i < 8; i++) begin
      clear_inputs();
      if (vecs[i].if_req) drive_if(vecs[i].if_addr);
      if (vecs[i].dm_req) drive_dm(vecs[i].dm_addr, vecs[i].dm_we, vecs[i].dm_be, vecs[i].dm_wdata);
      bus.mem_gnt_i = vecs[i].mem_gnt;
      sample();
      chk1("vec_if_gnt", bus.if_gnt_o, vecs[i].exp_if_gnt);
      chk1("vec_dm_gnt", bus.dm_gnt_o, vecs[i].exp_dm_gnt);
      chk1("vec_mem_req", bus.mem_req_o, vecs[i].exp_mem_req);
      if (vecs[i].exp_mem_req) begin
        chk32("vec_mem_addr", bus.mem_addr_o, vecs[i].exp_addr);
        chk1("vec_mem_we", bus.mem_we_o, vecs[i].exp_we);
        chk32("vec_mem_be", 32'(bus.mem_be_o), 32'(vecs[i].exp_be));
      end
      if (vecs[i].exp_dm_win) chk32("vec_mem_wdata", bus.mem_wdata_o, vecs[i].dm_wdata);
      tick();
      // idle cycle: answer the accepted request, if any
      clear_inputs();
      if (vecs[i].exp_if_gnt || vecs[i].exp_dm_gnt) begin
        d = 32'h1000 + 32'(i);
        respond(d);
        expect_rsp(vecs[i].exp_dm_gnt, (vecs[i].exp_dm_gnt && vecs[i].dm_we) ? 32'h0 : d);
      end
      sample();
      tick();
    end
    clear_inputs();

    // ---- contention: DM 8 cycles, IF on the 9th, repeating ----
    for (int k = 0; k < 18; k++) begin
      clear_inputs();
      drive_if(32'h400 + 32'(4 * k));
      drive_dm(32'h8000 + 32'(4 * k), 1'b0, 4'hF, 32'h0);
      bus.mem_gnt_i = 1'b1;
      if (k > 0) begin
        d = 32'hC000 + 32'(k - 1);
        respond(d);
        expect_rsp(((k - 1) % 9 == 8) ? 1'b0 : 1'b1, d);
      end
      sample();
      exp_if = (k % 9 == 8);
      chk1("cont_if_gnt", bus.if_gnt_o, exp_if);
      chk1("cont_dm_gnt", bus.dm_gnt_o, !exp_if);
      chk32("cont_starve", 32'(starve_cnt), 32'(k % 9));
      chk32("cont_addr", bus.mem_addr_o, exp_if ? 32'h400 + 32'(4 * k) : 32'h8000 + 32'(4 * k));
      tick();
    end
    clear_inputs();
    respond(32'hC000 + 32'd17);
    expect_rsp(1'b0, 32'hC000 + 32'd17);
    sample();
    chk32("cont_starve_clear", 32'(starve_cnt), 32'd0);
    tick();
    clear_inputs();

    // ---- in-order routing ----
    drive_if(32'h100);
    bus.mem_gnt_i = 1'b1;
    sample();
    chk1("ord_if_gnt0", bus.if_gnt_o, 1'b1);
    tick();
    bus.if_req_i = 1'b0;
    drive_dm(32'h2000, 1'b0, 4'hF, 32'h0);
    sample();
    chk1("ord_dm_gnt", bus.dm_gnt_o, 1'b1);
    tick();
    bus.dm_req_i = 1'b0;
    drive_if(32'h104);
    sample();
    chk1("ord_if_gnt1", bus.if_gnt_o, 1'b1);
    tick();
    clear_inputs();
    respond(32'hA);
    expect_rsp(1'b0, 32'hA);
    sample();
    chk32("ord_tag_cnt", 32'(tag_cnt), 32'd3);
    tick();
    respond(32'hB);
    expect_rsp(1'b1, 32'hB);
    sample();
    tick();
    respond(32'hC);
    expect_rsp(1'b0, 32'hC);
    sample();
    tick();
    clear_inputs();
    sample();
    chk32("ord_tag_cnt_end", 32'(tag_cnt), 32'd0);
    tick();

    // ---- flush: three fetches killed, redirect fetch survives ----
    for (int j = 0; j < 3; j++) begin
      drive_if(32'h200 + 32'(4 * j));
      bus.mem_gnt_i = 1'b1;
      sample();
      chk1("fl_if_gnt", bus.if_gnt_o, 1'b1);
      tick();
    end
    bus.flush_i = 1'b1;
    drive_if(32'h40);
    bus.mem_gnt_i = 1'b1;
    respond(32'h111);
    sample();
    chk1("fl_redirect_gnt", bus.if_gnt_o, 1'b1);
    chk32("fl_redirect_addr", bus.mem_addr_o, 32'h40);
    chk1("fl_drop_in_flush", bus.if_rvalid_o, 1'b0);
    tick();
    clear_inputs();
    respond(32'h222);
    sample();
    chk1("fl_drop_2", bus.if_rvalid_o, 1'b0);
    tick();
    respond(32'h333);
    sample();
    chk1("fl_drop_3", bus.if_rvalid_o, 1'b0);
    tick();
    respond(32'h4040);
    expect_rsp(1'b0, 32'h4040);
    sample();
    chk1("fl_redirect_rvalid", bus.if_rvalid_o, 1'b1);
    tick();
    clear_inputs();
    sample();
    chk32("fl_tag_cnt_end", 32'(tag_cnt), 32'd0);
    tick();

    // ---- full: no grant while full, even with a same-cycle response ----
    for (int j = 0; j < 4; j++) begin
      drive_dm(32'h500 + 32'(4 * j), 1'b0, 4'hF, 32'h0);
      bus.mem_gnt_i = 1'b1;
      sample();
      chk1("full_fill_gnt", bus.dm_gnt_o, 1'b1);
      tick();
    end
    drive_dm(32'h600, 1'b0, 4'hF, 32'h0);
    drive_if(32'h700);
    bus.mem_gnt_i = 1'b1;
    sample();
    chk1("full_mem_req", bus.mem_req_o, 1'b0);
    chk1("full_dm_gnt", bus.dm_gnt_o, 1'b0);
    chk1("full_if_gnt", bus.if_gnt_o, 1'b0);
    chk32("full_tag_cnt", 32'(tag_cnt), 32'd4);
    tick();
    respond(32'h5A0);
    expect_rsp(1'b1, 32'h5A0);
    sample();
    chk1("full_pop_mem_req", bus.mem_req_o, 1'b0);
    chk1("full_pop_dm_gnt", bus.dm_gnt_o, 1'b0);
    tick();
    bus.mem_rvalid_i = 1'b0;
    sample();
    chk1("full_after_mem_req", bus.mem_req_o, 1'b1);
    chk1("full_after_dm_gnt", bus.dm_gnt_o, 1'b1);
    chk32("full_after_addr", bus.mem_addr_o, 32'h600);
    tick();
    clear_inputs();
    for (int j = 0; j < 4; j++) begin
      d = 32'h5A1 + 32'(j);
      respond(d);
      expect_rsp(1'b1, d);
      sample();
      tick();
    end
    clear_inputs();
    sample();
    chk32("full_tag_cnt_end", 32'(tag_cnt), 32'd0);
    tick();

    // ---- store acknowledge: narrow byte enables, zero data back ----
    drive_dm(32'h80, 1'b1, 4'b0011, 32'hDEADBEEF);
    bus.mem_gnt_i = 1'b1;
    sample();
    chk32("st_mem_be", 32'(bus.mem_be_o), 32'h3);
    chk1("st_mem_we", bus.mem_we_o, 1'b1);
    chk32("st_mem_wdata", bus.mem_wdata_o, 32'hDEADBEEF);
    tick();
    clear_inputs();
    respond(32'h12345678);
    expect_rsp(1'b1, 32'h0);
    sample();
    chk1("st_dm_rvalid", bus.dm_rvalid_o, 1'b1);
    chk32("st_dm_rdata", bus.dm_rdata_o, 32'h0);
    tick();
    clear_inputs();

    sample();
    chk32("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
